// File: rtl/dp_operand_streamer_if.sv
// Operand bus of dp_operand_streamer: memory read port plus engine feed.
// master = streamer side, slave = buffer/engine side.
interface dp_operand_streamer_if #(
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int PARALLEL    = 2,
    parameter int VAL_SIZE    = 26,
    parameter int ADDR_W      = 8
);
    logic                            mem_en;
    logic [ADDR_W-1:0]               mem_addr;
    logic [PARALLEL*PIXEL_SIZE-1:0]  pix_rdata;
    logic [PARALLEL*WEIGHT_SIZE-1:0] wgt_rdata;
    logic                            dp_clear;
    logic [PARALLEL*PIXEL_SIZE-1:0]  Pixels;
    logic [PARALLEL*WEIGHT_SIZE-1:0] Weights;
    logic                            op_valid;
    logic [VAL_SIZE-1:0]             value;

    modport master (
        output mem_en, mem_addr, dp_clear, Pixels, Weights, op_valid,
        input  pix_rdata, wgt_rdata, value
    );

    modport slave (
        input  mem_en, mem_addr, dp_clear, Pixels, Weights, op_valid,
        output pix_rdata, wgt_rdata, value
    );
endinterface

// File: rtl/dp_operand_streamer.sv
// dp_operand_streamer: streams PIXEL_N pixel/weight pairs, PARALLEL lanes per
// beat, from a synchronous buffer into the dot-product engine, waits out the
// engine pipeline and captures its result.
// Optional feature: define DP_STREAM_ABORT_EN to add the abort input.
module dp_operand_streamer #(
    parameter int PIXEL_N      = 10,
    parameter int PIXEL_SIZE   = 10,
    parameter int WEIGHT_SIZE  = 19,
    parameter int PARALLEL     = 2,
    parameter int VAL_SIZE     = 26,
    parameter int DRAIN_CYCLES = 12,
    parameter int ADDR_W       = 8
) (
    input  logic                  clk,
    input  logic                  GlobalReset,
    input  logic                  start,
    output logic                  busy,
    dp_operand_streamer_if.master bus,
    output logic [VAL_SIZE-1:0]   result,
    output logic                  done
`ifdef DP_STREAM_ABORT_EN
    ,
    input  logic                  abort
`endif
);

    localparam int BEATS      = (PIXEL_N + PARALLEL - 1) / PARALLEL;
    localparam int LAST_LANES = PIXEL_N - (BEATS - 1) * PARALLEL;
    localparam int DRAIN_W    = $clog2(DRAIN_CYCLES + 1);

    localparam logic [ADDR_W-1:0]  LAST_BEAT  = ADDR_W'(BEATS - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  beat_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               clear_q;
    logic               beat_valid_q;
    logic               last_q;
    logic               run;
    logic               abort_hit;

    assign run = (state_q == S_RUN);

`ifdef DP_STREAM_ABORT_EN
    assign abort_hit = abort && (state_q == S_RUN || state_q == S_DRAIN);
`else
    assign abort_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (GlobalReset) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next state and state-decoded outputs.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        busy       = (state_q != S_IDLE);
        bus.mem_en = run;
        done       = (state_q == S_DONE);
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (beat_q == LAST_BEAT) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == LAST_DRAIN) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    // Beat/drain counters, beat qualifiers and result capture.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            beat_q       <= '0;
            drain_q      <= '0;
            clear_q      <= 1'b0;
            beat_valid_q <= 1'b0;
            last_q       <= 1'b0;
            result       <= '0;
        end else begin
            clear_q      <= (state_q == S_IDLE) && start;
            beat_valid_q <= run && !abort_hit;
            last_q       <= run && (beat_q == LAST_BEAT) && !abort_hit;

            if (run && state_d == S_RUN) beat_q <= beat_q + 1'b1;
            else                         beat_q <= '0;

            if (state_q == S_DRAIN && state_d == S_DRAIN) drain_q <= drain_q + 1'b1;
            else                                           drain_q <= '0;

            if (state_q == S_DRAIN && state_d == S_DONE) result <= bus.value;
        end
    end

    assign bus.mem_addr = beat_q;
    assign bus.dp_clear = clear_q;
    assign bus.op_valid = beat_valid_q;

    // Engine feed: the buffer's output register is the beat register, so the
    // read data is only gated here; idle cycles and padding lanes of the last
    // beat carry zeros so the engine keeps accumulating zero products.
    always_comb begin
        bus.Pixels  = '0;
        bus.Weights = '0;
        if (beat_valid_q) begin
            for (int j = 0; j < PARALLEL; j++) begin
                if (!last_q || j < LAST_LANES) begin
                    bus.Pixels[j*PIXEL_SIZE +: PIXEL_SIZE]   = bus.pix_rdata[j*PIXEL_SIZE +: PIXEL_SIZE];
                    bus.Weights[j*WEIGHT_SIZE +: WEIGHT_SIZE] = bus.wgt_rdata[j*WEIGHT_SIZE +: WEIGHT_SIZE];
                end
            end
        end
    end

endmodule
